// File: rtl/res_station.sv
// res_station: Tomasulo reservation station with CDB snooping, issue bypass and ALU dispatch.
// Define RS_AGE_ORDER_EN to dispatch the oldest READY entry instead of the lowest-index one.
module res_station #(
  parameter int ENTRIES    = 3,
  parameter int DATA_W     = 32,
  parameter int STATION_ID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [3:0]        issue_qj,
  input  logic [3:0]        issue_qk,
  output logic              isFull,
  output logic [3:0]        issue_tag,
  input  logic              cdb_valid,
  input  logic [3:0]        cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_tag
);

  typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} entryState_e;

  localparam logic [1:0] SID = 2'(STATION_ID);

  entryState_e       state [ENTRIES];
  entryState_e       stateNext [ENTRIES];
  logic [1:0]        op [ENTRIES];
  logic [1:0]        opNext [ENTRIES];
  logic [DATA_W-1:0] vj [ENTRIES];
  logic [DATA_W-1:0] vjNext [ENTRIES];
  logic [DATA_W-1:0] vk [ENTRIES];
  logic [DATA_W-1:0] vkNext [ENTRIES];
  logic [3:0]        qj [ENTRIES];
  logic [3:0]        qjNext [ENTRIES];
  logic [3:0]        qk [ENTRIES];
  logic [3:0]        qkNext [ENTRIES];

  logic               holdValid, holdValidNext;
  logic [1:0]         holdIdx, holdIdxNext;
  logic               freeFound, readyFound;
  logic [1:0]         freeIdx, selIdx;
  logic [ENTRIES-1:0] freeHit;
  logic               issueDo, dispatchDo, bypJ, bypK;
  logic [DATA_W-1:0]  newVj, newVk;
  logic [3:0]         newQj, newQk;

`ifdef RS_AGE_ORDER_EN
  // Age is the entry's rank among occupied entries: 0 is the oldest.
  logic [1:0] age [ENTRIES];
  logic [1:0] ageNext [ENTRIES];
  logic [1:0] bestAge, freeAge, keepCnt;
  logic       freeing;
`endif

  function automatic logic [3:0] tagOf(input int idx);
    return {SID, 2'(idx)};
  endfunction

  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (state[i] == FREE) begin
        freeFound = 1'b1;
        freeIdx   = 2'(i);
      end
    end
  end

  assign isFull    = !freeFound;
  assign issue_tag = isFull ? 4'h0 : {SID, freeIdx};

  // A stalled offer is pinned so a newly READY entry cannot change it mid-handshake.
  always_comb begin
    readyFound = 1'b0;
    selIdx     = '0;
`ifdef RS_AGE_ORDER_EN
    bestAge = 2'd3;
    for (int i = 0; i < ENTRIES; i++) begin
      if (state[i] == READY && (!readyFound || age[i] < bestAge)) begin
        readyFound = 1'b1;
        selIdx     = 2'(i);
        bestAge    = age[i];
      end
    end
`else
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (state[i] == READY) begin
        readyFound = 1'b1;
        selIdx     = 2'(i);
      end
    end
`endif
    if (holdValid) begin
      readyFound = 1'b1;
      selIdx     = holdIdx;
    end
  end

  assign alu_valid  = readyFound;
  assign alu_op     = op[selIdx];
  assign alu_a      = vj[selIdx];
  assign alu_b      = vk[selIdx];
  assign alu_tag    = {SID, selIdx};
  assign dispatchDo = alu_valid && alu_ready;

  always_comb begin
    freeHit = '0;
    for (int i = 0; i < ENTRIES; i++)
      freeHit[i] = (state[i] == EXEC) && cdb_valid && (cdb_tag == tagOf(i));
  end

  assign issueDo = issue_en && !isFull;
  assign bypJ    = cdb_valid && (issue_qj != 4'h0) && (issue_qj == cdb_tag);
  assign bypK    = cdb_valid && (issue_qk != 4'h0) && (issue_qk == cdb_tag);
  assign newVj   = bypJ ? cdb_data : issue_vj;
  assign newVk   = bypK ? cdb_data : issue_vk;
  assign newQj   = bypJ ? 4'h0 : issue_qj;
  assign newQk   = bypK ? 4'h0 : issue_qk;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      stateNext[i] = state[i];
      opNext[i]    = op[i];
      vjNext[i]    = vj[i];
      vkNext[i]    = vk[i];
      qjNext[i]    = qj[i];
      qkNext[i]    = qk[i];
      case (state[i])
        FREE: begin
          if (issueDo && freeIdx == 2'(i)) begin
            opNext[i]    = issue_op;
            vjNext[i]    = newVj;
            vkNext[i]    = newVk;
            qjNext[i]    = newQj;
            qkNext[i]    = newQk;
            stateNext[i] = (newQj == 4'h0 && newQk == 4'h0) ? READY : WAIT;
          end
        end
        WAIT: begin
          if (cdb_valid && qj[i] != 4'h0 && qj[i] == cdb_tag) begin
            vjNext[i] = cdb_data;
            qjNext[i] = 4'h0;
          end
          if (cdb_valid && qk[i] != 4'h0 && qk[i] == cdb_tag) begin
            vkNext[i] = cdb_data;
            qkNext[i] = 4'h0;
          end
          if (qjNext[i] == 4'h0 && qkNext[i] == 4'h0) stateNext[i] = READY;
        end
        READY: if (dispatchDo && selIdx == 2'(i)) stateNext[i] = EXEC;
        EXEC:  if (freeHit[i]) stateNext[i] = FREE;
        default: ;
      endcase
    end
    holdValidNext = alu_valid && !alu_ready;
    holdIdxNext   = selIdx;
  end

`ifdef RS_AGE_ORDER_EN
  // Survivors younger than a freed entry move up one rank; a new entry ranks behind all survivors.
  always_comb begin
    freeing = 1'b0;
    freeAge = '0;
    keepCnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (freeHit[i]) begin
        freeing = 1'b1;
        freeAge = age[i];
      end
    end
    for (int i = 0; i < ENTRIES; i++)
      if (state[i] != FREE && !freeHit[i]) keepCnt = keepCnt + 2'd1;
    for (int i = 0; i < ENTRIES; i++) begin
      ageNext[i] = age[i];
      if (state[i] == FREE) begin
        if (issueDo && freeIdx == 2'(i)) ageNext[i] = keepCnt;
      end else if (freeing && age[i] > freeAge) begin
        ageNext[i] = age[i] - 2'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state[i] <= FREE;
        op[i]    <= '0;
        vj[i]    <= '0;
        vk[i]    <= '0;
        qj[i]    <= '0;
        qk[i]    <= '0;
`ifdef RS_AGE_ORDER_EN
        age[i]   <= '0;
`endif
      end
      holdValid <= 1'b0;
      holdIdx   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        state[i] <= stateNext[i];
        op[i]    <= opNext[i];
        vj[i]    <= vjNext[i];
        vk[i]    <= vkNext[i];
        qj[i]    <= qjNext[i];
        qk[i]    <= qkNext[i];
`ifdef RS_AGE_ORDER_EN
        age[i]   <= ageNext[i];
`endif
      end
      holdValid <= holdValidNext;
      holdIdx   <= holdIdxNext;
    end
  end

endmodule
